// File: rtl/lz77_hash_bucket_ram.sv
// lz77_hash_bucket_ram: multi-way hash bucket table with a post-reset valid-clear sweep
module lz77_hash_bucket_ram #(
    parameter int HASH_BITS  = 12,
    parameter int DATA_WIDTH = 14,
    parameter int WAYS       = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [HASH_BITS-1:0]       addr,
    input  logic                       wen,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic                       ren,
    output logic [WAYS*DATA_WIDTH-1:0] rdata,
    output logic [WAYS-1:0]            rvalid,
    output logic                       busy
);
    localparam int DEPTH = 1 << HASH_BITS;
    localparam int BW    = WAYS * DATA_WIDTH;
    localparam int EW    = BW + WAYS;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                state_q, state_d;
    logic [HASH_BITS-1:0]  cnt_q;
    logic [HASH_BITS-1:0]  wa_q;
    logic                  ren_q, wen_q, fwd_hit_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [EW-1:0]         mem [DEPTH];
    logic [EW-1:0]         mem_rd, fwd_q, cur, nxt, mem_wd;
    logic [BW-1:0]         hold_data_q;
    logic [WAYS-1:0]       hold_vld_q;
    logic                  run, mem_we;
    logic [HASH_BITS-1:0]  mem_wa;

    assign run  = state_q == RUN;
    assign busy = state_q == CLEAR;

    // Sweep bookkeeping: leave CLEAR once the last bucket has been invalidated
    always_comb begin
        state_d = state_q;
        if (state_q == CLEAR && &cnt_q) state_d = RUN;
    end

    // State register and sweep counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= busy ? cnt_q + 1'b1 : cnt_q;
        end
    end

    // Bucket seen by the access in its second cycle; a write one cycle earlier
    // to the same bucket is newer than the RAM read and is forwarded instead.
    // Each bucket word is {valid flags, entries}, way 0 in the low bits.
    always_comb begin
        cur    = fwd_hit_q ? fwd_q : mem_rd;
        nxt    = {(cur[EW-1:BW] << 1) | WAYS'(1), (cur[BW-1:0] << DATA_WIDTH) | BW'(wdata_q)};
        mem_we = busy | wen_q;
        mem_wa = busy ? cnt_q : wa_q;
        mem_wd = busy ? '0 : nxt;
        rdata  = ren_q ? cur[BW-1:0] : hold_data_q;
        rvalid = ren_q ? cur[EW-1:BW] : hold_vld_q;
    end

    // Bucket storage: single write port, registered read, no reset
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
        mem_rd <= mem[addr];
    end

    // Access pipeline, forwarding register and read-result hold register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ren_q       <= 1'b0;
            wen_q       <= 1'b0;
            wa_q        <= '0;
            wdata_q     <= '0;
            fwd_hit_q   <= 1'b0;
            fwd_q       <= '0;
            hold_data_q <= '0;
            hold_vld_q  <= '0;
        end else begin
            ren_q     <= run & ren;
            wen_q     <= run & wen;
            wa_q      <= addr;
            wdata_q   <= wdata;
            fwd_hit_q <= wen_q & (wa_q == addr);
            fwd_q     <= nxt;
            if (ren_q) begin
                hold_data_q <= cur[BW-1:0];
                hold_vld_q  <= cur[EW-1:BW];
            end
        end
    end
endmodule

// File: tb/tb_lz77_hash_bucket_ram.sv
// tb_lz77_hash_bucket_ram: directed and random checks against a bucket-list model
module tb_lz77_hash_bucket_ram;
    logic        clk = 0, rst = 1, wen = 0, ren = 0;
    logic [3:0]  addr = 0;
    logic [13:0] wdata = 0;
    logic [27:0] rdata;
    logic [1:0]  rvalid;
    logic        busy;

    int          tests = 0, fails = 0, sweep_left = 0;
    logic [13:0] md [16][2];
    logic [1:0]  mv [16];
    logic [27:0] exp_rd = 0;
    logic [1:0]  exp_rv = 0;

    lz77_hash_bucket_ram #(.HASH_BITS(4), .DATA_WIDTH(14), .WAYS(2)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wen(wen), .wdata(wdata),
        .ren(ren), .rdata(rdata), .rvalid(rvalid), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [27:0] msk(input logic [27:0] d, input logic [1:0] v);
        return {v[1] ? d[27:14] : 14'h0, v[0] ? d[13:0] : 14'h0};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic w, input logic [3:0] a, input logic [13:0] d);
        ren = r; wen = w; addr = a; wdata = d;
        @(posedge clk); #1;
        if (sweep_left > 0) sweep_left--;
        else begin
            if (r) begin
                exp_rd = {md[a][1], md[a][0]};
                exp_rv = mv[a];
            end
            if (w) begin
                md[a][1] = md[a][0];
                md[a][0] = d;
                mv[a]    = {mv[a][0], 1'b1};
            end
        end
        check("busy", 32'(busy), 32'(sweep_left > 0));
        check("rvalid", 32'(rvalid), 32'(exp_rv));
        check("rdata", 32'(msk(rdata, exp_rv)), 32'(msk(exp_rd, exp_rv)));
        if (busy !== 1'b0) check("clr_rdata", 32'(rdata), 32'(0));
    endtask

    task automatic rnd(input int n, input int amax);
        for (int i = 0; i < n; i++)
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, amax)), 14'($urandom));
    endtask

    task automatic do_reset(input int n);
        rst = 1; wen = 1; ren = 1;
        #1;
        for (int i = 0; i < 16; i++) mv[i] = 2'b00;
        exp_rd = 0; exp_rv = 0;
        check("rst_busy", 32'(busy), 32'(1));
        check("rst_rdata", 32'(rdata), 32'(0));
        check("rst_rvalid", 32'(rvalid), 32'(0));
        repeat (n) @(posedge clk);
        #1;
        rst = 0;
        sweep_left = 16;
    endtask

    task automatic read_all();
        for (int i = 0; i < 16; i++) begin
            cyc(1, 0, 4'(i), 0);
            check("swept_rvalid", 32'(rvalid), 32'(0));
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            md[i][0] = 0; md[i][1] = 0; mv[i] = 0;
        end
        do_reset(2);
        rnd(16, 15);
        cyc(0, 1, 3, 14'h0101);
        cyc(0, 1, 3, 14'h0202);
        cyc(1, 0, 3, 0);
        check("two_writes_rdata", 32'(rdata), 32'({14'h0101, 14'h0202}));
        check("two_writes_rvalid", 32'(rvalid), 32'(2'b11));
        cyc(0, 1, 7, 14'h1);
        cyc(0, 1, 7, 14'h2);
        cyc(0, 1, 7, 14'h3);
        cyc(1, 0, 7, 0);
        check("three_writes_rdata", 32'(rdata), 32'({14'h2, 14'h3}));
        check("three_writes_rvalid", 32'(rvalid), 32'(2'b11));
        cyc(0, 1, 5, 14'h10);
        cyc(1, 1, 5, 14'h20);
        check("rbw_way0", 32'(rdata[13:0]), 32'(14'h10));
        check("rbw_rvalid", 32'(rvalid), 32'(2'b01));
        cyc(1, 0, 5, 0);
        check("after_rbw_rdata", 32'(rdata), 32'({14'h10, 14'h20}));
        check("after_rbw_rvalid", 32'(rvalid), 32'(2'b11));
        cyc(1, 0, 3, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, (i % 2) ? 4'd3 : 4'd4, 14'($urandom));
            check("hold_rdata", 32'(rdata), 32'({14'h0101, 14'h0202}));
            check("hold_rvalid", 32'(rvalid), 32'(2'b11));
        end
        rnd(300, 3);
        rnd(200, 15);
        do_reset(3);
        rnd(16, 15);
        read_all();
        rnd(40, 3);
        do_reset(1);
        for (int i = 0; i < 8; i++) cyc(1, 1, 4'(i), 14'($urandom));
        do_reset(2);
        for (int i = 0; i < 16; i++) cyc(1, 1, 4'(i), 14'($urandom));
        read_all();
        rnd(100, 2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
